// File: rtl/weight_loader.sv
// Weight loader: fetches weight_dim rows from the weight buffer (last row first),
// shifts them into the systolic array, then kicks the convolution controller.
module weight_loader #(
  parameter int col = 32,
  parameter int dw  = 8,
  parameter int aw  = 10
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [4:0]        weight_dim,
  input  logic [aw-1:0]     base_addr,
  input  logic              conv_finish,
  output logic              rd_en,
  output logic [aw-1:0]     rd_addr,
  input  logic [col*dw-1:0] rd_data,
  output logic [col*dw-1:0] w_data,
  output logic              w_valid,
  output logic              conv_ctrl,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_KICK,
    S_WAIT
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [4:0]        r_n;
  logic [4:0]        r_cnt;
  logic [4:0]        w_cnt_nxt;
  logic [4:0]        w_offset;
  logic [aw-1:0]     r_base;
  logic              r_rd_vld;
  logic              r_w_valid;
  logic              r_err;
  logic [col*dw-1:0] r_w_data;
  logic              w_legal;
  logic              w_accept;

  assign w_legal  = (weight_dim == 5'd4)  || (weight_dim == 5'd9) ||
                    (weight_dim == 5'd16) || (weight_dim == 5'd25);
  assign w_accept = (r_state == S_IDLE) && start && w_legal;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_offset    = '0;
    rd_en       = 1'b0;
    rd_addr     = '0;
    conv_ctrl   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_accept) begin
          w_state_nxt = S_LOAD;
          w_cnt_nxt   = '0;
        end
      end
      S_LOAD: begin
        // Rows are read in reverse so row 0 lands at the top of the array.
        rd_en    = 1'b1;
        w_offset = r_n - 5'd1 - r_cnt;
        rd_addr  = r_base + aw'(w_offset);
        if (r_cnt == r_n - 5'd1) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 5'd1;
        end
      end
      S_DRAIN: begin
        if (r_cnt == 5'd1) begin
          w_state_nxt = S_KICK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 5'd1;
        end
      end
      S_KICK: begin
        conv_ctrl   = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (conv_finish) w_state_nxt = S_IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt     <= '0;
      r_n       <= '0;
      r_base    <= '0;
      r_rd_vld  <= 1'b0;
      r_w_valid <= 1'b0;
      r_w_data  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_accept) begin
        r_n    <= weight_dim;
        r_base <= base_addr;
      end
      // Buffer data trails rd_en by one cycle; w_data is forced to zero between beats.
      r_rd_vld  <= rd_en;
      r_w_valid <= r_rd_vld;
      r_w_data  <= r_rd_vld ? rd_data : '0;
      r_err     <= (r_state == S_IDLE) && start && !w_legal;
    end
  end

  assign w_data  = r_w_data;
  assign w_valid = r_w_valid;
  assign err     = r_err;

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader: job-level reference model, per-cycle
// compare process, directed literal checks and randomized jobs.
module tb_weight_loader;

  localparam int COL = 32;
  localparam int DW  = 8;
  localparam int AW  = 10;
  localparam int WB  = COL * DW;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          start = 1'b0;
  logic [4:0]    weight_dim = '0;
  logic [AW-1:0] base_addr = '0;
  logic          conv_finish = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [WB-1:0] rd_data = '0;
  logic [WB-1:0] w_data;
  logic          w_valid;
  logic          conv_ctrl;
  logic          busy;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  weight_loader #(.col(COL), .dw(DW), .aw(AW)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .weight_dim (weight_dim),
    .base_addr  (base_addr),
    .conv_finish(conv_finish),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .w_data     (w_data),
    .w_valid    (w_valid),
    .conv_ctrl  (conv_ctrl),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [WB-1:0] act, input logic [WB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Distinct, address-dependent row contents.
  function automatic logic [WB-1:0] pat(input logic [AW-1:0] a);
    logic [WB-1:0] r;
    for (int j = 0; j < COL; j++)
      r[j*DW +: DW] = 8'((int'(a) * 29 + j * 113 + (int'(a) >> 5)) & 255);
    return r;
  endfunction

  function automatic bit legal(input logic [4:0] n);
    return n == 5'd4 || n == 5'd9 || n == 5'd16 || n == 5'd25;
  endfunction

  // Buffer: one-cycle read latency, junk on idle cycles.
  always @(posedge clk)
    rd_data <= rd_en ? pat(rd_addr) : {8{$urandom()}};

  // Job-level reference model: a job accepted at cycle t0 with N rows.
  int            m_cyc = 0;
  bit            m_act = 1'b0;
  bit            m_errp = 1'b0;
  int            m_t0 = 0;
  int            m_n = 0;
  logic [AW-1:0] m_base = '0;

  always @(posedge clk) begin
    if (!nrst) begin
      m_act  = 1'b0;
      m_errp = 1'b0;
    end else begin
      m_errp = 1'b0;
      if (m_act) begin
        if ((m_cyc - m_t0) >= m_n + 4 && conv_finish) m_act = 1'b0;
      end else if (start) begin
        if (legal(weight_dim)) begin
          m_act  = 1'b1;
          m_t0   = m_cyc;
          m_n    = int'(weight_dim);
          m_base = base_addr;
        end else begin
          m_errp = 1'b1;
        end
      end
    end
    m_cyc++;
  end

  always @(negedge nrst) begin
    m_act  = 1'b0;
    m_errp = 1'b0;
  end

  always @(negedge clk) begin
    int d;
    logic e_rd, e_wv, e_cc, e_busy, e_err;
    logic [AW-1:0] e_addr;
    logic [WB-1:0] e_wd;
    e_rd = 0; e_wv = 0; e_cc = 0; e_busy = 0; e_err = 0; e_addr = '0; e_wd = '0;
    if (nrst) begin
      e_err = m_errp;
      if (m_act) begin
        d      = m_cyc - m_t0;
        e_busy = 1'b1;
        e_rd   = (d >= 1 && d <= m_n);
        e_addr = m_base + AW'(m_n - d);
        e_wv   = (d >= 3 && d <= m_n + 2);
        if (e_wv) e_wd = pat(m_base + AW'(m_n + 2 - d));
        e_cc   = (d == m_n + 3);
      end
    end
    chk("rd_en", WB'(rd_en), WB'(e_rd));
    if (e_rd) chk("rd_addr", WB'(rd_addr), WB'(e_addr));
    chk("w_valid", WB'(w_valid), WB'(e_wv));
    chk("w_data", w_data, e_wd);
    chk("conv_ctrl", WB'(conv_ctrl), WB'(e_cc));
    chk("busy", WB'(busy), WB'(e_busy));
    chk("err", WB'(err), WB'(e_err));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Runs one job from IDLE and returns what was observed; optionally injects
  // ignored start/conv_finish pulses and leaves start high through conv_finish.
  task automatic run_job(input logic [4:0] n, input logic [AW-1:0] base, input bit noise,
                         input bit hold, input int fin_wait,
                         output int kick, output int rd_first, output logic [AW-1:0] a_first,
                         output logic [AW-1:0] a_last, output int beats, output int kicks);
    start = 1'b1; weight_dim = n; base_addr = base; conv_finish = 1'b0;
    cyc();
    start = 1'b0; weight_dim = 5'($urandom_range(0, 31)); base_addr = AW'($urandom());
    kick = -1; rd_first = -1; beats = 0; kicks = 0; a_first = '0; a_last = '0;
    for (int i = 1; i <= int'(n) + 6 + fin_wait; i++) begin
      if (rd_en) begin
        if (rd_first < 0) begin rd_first = i; a_first = rd_addr; end
        a_last = rd_addr;
      end
      if (w_valid) beats++;
      if (conv_ctrl) begin kicks++; if (kick < 0) kick = i; end
      if (noise) begin
        start       = (i == 2) || (i == int'(n) + 5);
        weight_dim  = 5'd4;
        conv_finish = (i == 3) || (i == int'(n) + 3);
      end
      cyc();
    end
    start = hold; conv_finish = 1'b1;
    if (hold) begin weight_dim = 5'd4; base_addr = AW'($urandom()); end
    cyc();
    conv_finish = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kick, rdf, beats, kicks, cnt_cc, cnt_busy;
    logic [AW-1:0] af, al;
    logic [4:0] dims [4];
    dims[0] = 5'd4; dims[1] = 5'd9; dims[2] = 5'd16; dims[3] = 5'd25;

    #1;
    chk("reset_busy", WB'(busy), '0);
    chk("reset_wvalid", WB'(w_valid), '0);
    chk("reset_wdata", w_data, '0);
    repeat (3) cyc();
    nrst = 1'b1;
    repeat (2) cyc();

    run_job(5'd9, 10'h040, 0, 0, 3, kick, rdf, af, al, beats, kicks);
    chk("n9_first_addr", WB'(af), WB'(10'h048));
    chk("n9_last_addr", WB'(al), WB'(10'h040));
    chk("n9_rd_first", WB'(rdf), WB'(1));
    chk("n9_kick", WB'(kick), WB'(12));
    chk("n9_beats", WB'(beats), WB'(9));
    chk("n9_kicks", WB'(kicks), WB'(1));
    cyc();

    run_job(5'd25, 10'h3F0, 0, 0, 2, kick, rdf, af, al, beats, kicks);
    chk("n25_first_addr", WB'(af), WB'(10'h008));
    chk("n25_last_addr", WB'(al), WB'(10'h3F0));
    chk("n25_kick", WB'(kick), WB'(28));
    chk("n25_beats", WB'(beats), WB'(25));
    cyc();

    start = 1'b1; weight_dim = 5'd7; base_addr = 10'h100;
    cyc();
    start = 1'b0;
    chk("illegal_err", WB'(err), WB'(1));
    chk("illegal_rd_en", WB'(rd_en), '0);
    chk("illegal_busy", WB'(busy), '0);
    cyc();
    chk("illegal_err_clear", WB'(err), '0);
    run_job(5'd4, 10'h200, 0, 0, 1, kick, rdf, af, al, beats, kicks);
    chk("n4_kick", WB'(kick), WB'(7));

    run_job(5'd9, 10'h123, 1, 0, 4, kick, rdf, af, al, beats, kicks);
    chk("noise_kicks", WB'(kicks), WB'(1));
    chk("noise_kick", WB'(kick), WB'(12));
    chk("noise_busy_held", WB'(busy), '0);
    cyc();

    start = 1'b1; weight_dim = 5'd16; base_addr = 10'h0F0;
    cyc();
    start = 1'b0;
    repeat (4) cyc();
    #2 nrst = 1'b0;
    #1;
    chk("rst_rd_en", WB'(rd_en), '0);
    chk("rst_rd_addr", WB'(rd_addr), '0);
    chk("rst_busy", WB'(busy), '0);
    chk("rst_wvalid", WB'(w_valid), '0);
    chk("rst_wdata", w_data, '0);
    chk("rst_conv_ctrl", WB'(conv_ctrl), '0);
    cyc();
    nrst = 1'b1;
    cnt_cc = 0; cnt_busy = 0;
    for (int i = 0; i < 30; i++) begin
      if (conv_ctrl) cnt_cc++;
      if (busy) cnt_busy++;
      cyc();
    end
    chk("post_rst_conv_ctrl", WB'(cnt_cc), '0);
    chk("post_rst_busy", WB'(cnt_busy), '0);
    run_job(5'd16, 10'h0F0, 0, 0, 2, kick, rdf, af, al, beats, kicks);
    chk("n16_kick", WB'(kick), WB'(19));
    chk("n16_beats", WB'(beats), WB'(16));

    run_job(5'd4, 10'h010, 0, 1, 2, kick, rdf, af, al, beats, kicks);
    run_job(5'd4, base_addr, 0, 0, 2, kick, rdf, af, al, beats, kicks);
    chk("b2b_rd_first", WB'(rdf), WB'(1));
    chk("b2b_kick", WB'(kick), WB'(7));
    cyc();

    for (int j = 0; j < 12; j++) begin
      logic [4:0] n;
      n = dims[$urandom_range(0, 3)];
      if ($urandom_range(0, 2) == 0) begin
        start = 1'b1;
        weight_dim = 5'($urandom_range(0, 31));
        if (legal(weight_dim)) weight_dim = 5'd0;
        cyc();
        start = 1'b0;
      end
      run_job(n, AW'($urandom()), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 5)), kick, rdf, af, al, beats, kicks);
      chk("rand_kick", WB'(kick), WB'(int'(n) + 3));
      chk("rand_beats", WB'(beats), WB'(n));
      start = 1'b0;
      repeat ($urandom_range(0, 2)) cyc();
    end
    repeat (30) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
